ex_div_iter: RTL and testbench
==============================

# ex_div_iter

Iterative 32-bit radix-2 divider that sits behind the execute-stage pipeline register and drives that stage's `cur_stall`. It is the responder end of the stage's valid/allowin handshake. It accepts operands when the stage holds a valid divide instruction, holds the stage stalled while iterating, and presents a 64-bit `{remainder, quotient}` result for the stage to forward as `div_res`. It keeps that result stable until the stage actually hands the instruction to the next stage.

## Interface
Parameters:
- none; operand width fixed at 32.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `div_start`  in  1  stage holds a valid divide (`reg_valid && sig_div`); level, not pulse.
- `div_sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- `dividend`  in  32  rs operand; sampled with start.
- `divisor`  in  32  rt operand; sampled with start.
- `div_accept`  in  1  stage hands off this cycle (`goon_valid && post_allowin`).
- `div_cancel`  in  1  flush of the stage (exception/redirect); highest priority after reset.
- `div_stall`  out  1  to stage `cur_stall`; combinational.
- `div_done`  out  1  result valid (state DONE).
- `div_res`  out  64  `{remainder[63:32], quotient[31:0]}`, maps to hi/lo.

Reset: one clock; reset is asynchronous and active-low. Outputs at reset: `div_stall` = 0, `div_done` = 0, `div_res` = 0, and state = IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE to BUSY on `div_start && !div_cancel`. This edge latches the magnitudes `|dividend|` and `|divisor|` (absolute value when `div_sign`, else raw), the quotient sign `q_neg = sign(a)^sign(b)` and the remainder sign `r_neg = sign(a)`, and sets counter = 31.
- BUSY performs one restoring step per cycle:
  - `{rem, quo} <<= 1`.
  - If `rem >= divisor_mag` (33-bit compare), subtract and set `quo[0]`.
  - The counter decrements.
  - On the step with counter == 0, apply sign fixup (two's-complement negate `quo` if `q_neg`, negate `rem` if `r_neg`), write `div_res`, and go to DONE.
- Divide by zero: when the latched divisor is 0, the final result is forced to quotient = 32'hFFFF_FFFF and remainder = original dividend, in both signed and unsigned modes.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. Unsigned 33-bit magnitude arithmetic yields this naturally; it must not be special-cased incorrectly.
- DONE:
  - `div_res` is held and `div_stall` = 0.
  - On `div_accept`, go to IDLE. `div_res` keeps its value; only `div_done` clears.
  - A `div_start` still high in DONE (stage blocked by `post_allowin`) must not relaunch.
- `div_stall = (state==IDLE && div_start && !div_cancel) || (state==BUSY && !div_cancel)`.
- `div_cancel` in any state goes to IDLE at the next edge. It discards the partial result, leaves `div_res` unchanged and clears `div_done`.
- Asynchronous reset mid-BUSY aborts immediately. Outputs take their reset values without waiting for a clock.

## Timing
- `div_start` seen in IDLE at cycle T:
  - `div_stall` is high in cycles T through T+32 (33 cycles).
  - At T+33, `div_done` = 1, `div_stall` = 0 and `div_res` is valid.
- The stage advances at T+33 at the earliest. Total divide latency is 34 cycles including the sampling cycle.
- `div_accept` and `div_start` high together in DONE: go to IDLE only. A new start needs the next instruction's `div_start` in a later IDLE cycle. A back-to-back divide therefore starts in the cycle after the handoff edge.
- `div_cancel` and `div_start` high together in IDLE: no launch, `div_stall` = 0.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE on start, if divisor is 0 or `|dividend| < |divisor|`, skip BUSY and go straight to DONE at T+1.
  - The result is quotient 0 and remainder = original dividend. For a divisor of 0 it is the divide-by-zero result instead.
  - `div_stall` is high in cycle T only.
- `DIV_EARLY_OUT_EN` undefined: every divide takes the full 33-cycle stall, with identical results.

## Test plan
- Unsigned 100 / 7 (`div_sign` = 0): stall exactly 33 cycles, then `div_res` = {32'd2, 32'd14}, `div_done` = 1.
- Signed sign fixup: −7 / 2 gives {0xFFFF_FFFF, 0xFFFF_FFFD}. 7 / −2 gives {0x0000_0001, 0xFFFF_FFFD}. 0x8000_0000 / 0xFFFF_FFFF gives {0, 0x8000_0000}.
- Divide by zero: 0x1234_5678 / 0, signed and unsigned, gives {0x1234_5678, 0xFFFF_FFFF}.
- Hold in DONE: keep `div_start` = 1 and `div_accept` = 0 for 5 cycles after done. `div_stall` stays 0, `div_res` stays stable and no relaunch occurs. Asserting `div_accept` then returns to IDLE, and a new start stalls 33 cycles.
- Cancel and reset mid-BUSY:
  - `div_cancel` at T+10 drops stall in the same cycle and gives IDLE at T+11; `div_res` keeps its old value.
  - `resetn` low at T+5 zeroes all outputs asynchronously.
- With `DIV_EARLY_OUT_EN`: 3 / 10 stalls 1 cycle, then {3, 0}. 100 / 7 still stalls 33 cycles.

Source files
------------

// File: rtl/ex_div_iter.sv
// ex_div_iter -- iterative 32-bit radix-2 restoring divider for the execute stage.
//
// Accepts operands while the stage holds a valid divide instruction, stalls the
// stage for the duration of the iteration, and then holds {remainder, quotient}
// until the stage hands the instruction on.
//
// Ports:
//   clk         in   1   clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   div_start   in   1   stage holds a valid divide (level)
//   div_sign    in   1   1 = signed DIV, 0 = unsigned DIVU (sampled with start)
//   dividend    in  32   rs operand (sampled with start)
//   divisor     in  32   rt operand (sampled with start)
//   div_accept  in   1   stage hands the instruction off this cycle
//   div_cancel  in   1   stage flush; aborts any divide in progress
//   div_stall   out  1   stage stall request (combinational)
//   div_done    out  1   result valid
//   div_res     out 64   {remainder, quotient}
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, a zero divisor or |dividend| < |divisor| skips the iteration
//   and completes one cycle after start.

module ex_div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        div_accept,
  input  logic        div_cancel,
  output logic        div_stall,
  output logic        div_done,
  output logic [63:0] div_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;

  // Operand preparation from the live inputs (used only on the launch edge).
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign a_neg = div_sign & dividend[31];
  assign b_neg = div_sign & divisor[31];
  assign a_mag = a_neg ? (~dividend + 32'd1) : dividend;
  assign b_mag = b_neg ? (~divisor + 32'd1) : divisor;

  // One restoring step. The remainder is always below the divisor magnitude
  // before the shift, so after the shift it needs 33 bits for the compare but
  // the selected result fits back into 32 bits.
  logic [32:0] rem_sh;
  logic [32:0] rem_sub;
  logic [32:0] rem_sel;
  logic        rem_sel_unused;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] quo_fin, rem_fin;
  logic [63:0] res_fin;

  assign rem_sh         = {rem_q, quo_q[31]};
  assign rem_sub        = rem_sh - {1'b0, dvs_q};
  assign ge             = (rem_sh >= {1'b0, dvs_q});
  assign rem_sel        = ge ? rem_sub : rem_sh;
  assign rem_nx         = rem_sel[31:0];
  assign rem_sel_unused = rem_sel[32];
  assign quo_nx         = {quo_q[30:0], ge};

  assign quo_fin = q_neg_q ? (~quo_nx + 32'd1) : quo_nx;
  assign rem_fin = r_neg_q ? (~rem_nx + 32'd1) : rem_nx;
  // Divide by zero bypasses sign fixup: the raw restoring result would be
  // quotient all-ones / remainder |dividend|, which fixup would corrupt.
  assign res_fin = (dvs_q == 32'd0) ? {dvd_q, 32'hFFFF_FFFF} : {rem_fin, quo_fin};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          dvd_d   = dividend;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          cnt_d   = 5'd31;
`ifdef DIV_EARLY_OUT_EN
          if (divisor == 32'd0) begin
            res_d   = {dividend, 32'hFFFF_FFFF};
            state_d = S_DONE;
          end else if (a_mag < b_mag) begin
            res_d   = {dividend, 32'd0};
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
`else
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          res_d   = res_fin;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A start still asserted here belongs to the same instruction; only
        // the handoff returns to IDLE.
        if (div_accept) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides everything, including a result written this cycle.
    if (div_cancel) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Gated by resetn so the stall is low throughout reset even if the stage
  // still presents a start.
  assign div_stall = resetn & !div_cancel &
                     (((state_q == S_IDLE) & div_start) | (state_q == S_BUSY));
  assign div_done  = (state_q == S_DONE);
  assign div_res   = res_q;

endmodule

// File: tb/tb_ex_div_iter.sv
// Testbench for ex_div_iter: table-driven divide vectors plus hand-written
// sequences for hold-in-DONE, cancel mid-BUSY and asynchronous reset mid-BUSY.

module tb_ex_div_iter;

  logic        clk;
  logic        resetn;
  logic        div_start;
  logic        div_sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        div_accept;
  logic        div_cancel;
  logic        div_stall;
  logic        div_done;
  logic [63:0] div_res;

  ex_div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_sign   (div_sign),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_accept (div_accept),
    .div_cancel (div_cancel),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .div_res    (div_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    string       name;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;   // {remainder, quotient}
    logic        eo;    // qualifies for early out
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Counts stall cycles from the current cycle until div_done, sampled on the
  // falling edge; bounded so a hung divider still reaches the summary.
  task automatic wait_done(output int stalls, output bit ok);
    stalls = 0;
    ok     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_done) begin
        ok = 1'b1;
        break;
      end
      if (div_stall) stalls++;
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    div_start = 1'b1;
    div_sign  = s;
    dividend  = a;
    divisor   = b;
  endtask

  // Hand off with start still high in the same cycle; no relaunch expected.
  task automatic handoff(input string name, input logic [63:0] exp_res);
    @(posedge clk); #1;
    div_accept = 1'b1;
    @(posedge clk); #1;
    div_accept = 1'b0;
    div_start  = 1'b0;
    @(negedge clk);
    chk({name, " done clears"}, {63'd0, div_done}, 64'd0);
    chk({name, " res kept"}, div_res, exp_res);
  endtask

  int full_stall;
  int stalls;
  bit ok;
  logic [63:0] held;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
`ifdef DIV_EARLY_OUT_EN
    full_stall = 33;
`else
    full_stall = 33;
`endif

    vecs[0]  = '{"u100/7",      1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        1'b0};
    vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0};
    vecs[2]  = '{"s7/-2",       1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 1'b0};
    vecs[3]  = '{"s_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}, 1'b0};
    vecs[4]  = '{"s_div0",      1'b1, 32'h1234_5678, 32'd0,         {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1};
    vecs[5]  = '{"u_div0",      1'b0, 32'h1234_5678, 32'd0,         {32'h1234_5678, 32'hFFFF_FFFF}, 1'b1};
    vecs[6]  = '{"u_max/1",     1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0,         32'hFFFF_FFFF}, 1'b0};
    vecs[7]  = '{"u_8000/ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0},         1'b1};
    vecs[8]  = '{"u3/10",       1'b0, 32'd3,         32'd10,        {32'd3,         32'd0},         1'b1};
    vecs[9]  = '{"s-100/-7",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        1'b0};
    vecs[10] = '{"u_max/max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0,         32'd1},         1'b0};
    vecs[11] = '{"s-1/0",       1'b1, 32'hFFFF_FFFF, 32'd0,         {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b1};

    // Reset with a start already present: outputs must be quiet.
    resetn     = 1'b0;
    div_start  = 1'b1;
    div_sign   = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    div_accept = 1'b0;
    div_cancel = 1'b0;
    #1;
    chk("rst stall", {63'd0, div_stall}, 64'd0);
    chk("rst done",  {63'd0, div_done},  64'd0);
    chk("rst res",   div_res,            64'd0);
    div_start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      int exp_stall;
      exp_stall = 33;
`ifdef DIV_EARLY_OUT_EN
      if (vecs[i].eo) exp_stall = 1;
`endif
      launch(vecs[i].sign, vecs[i].a, vecs[i].b);
      wait_done(stalls, ok);
      chk({vecs[i].name, " finished"}, {63'd0, ok}, 64'd1);
      chk({vecs[i].name, " stall cycles"}, 64'(stalls), 64'(exp_stall));
      chk({vecs[i].name, " res"}, div_res, vecs[i].res);
      chk({vecs[i].name, " stall low in done"}, {63'd0, div_stall}, 64'd0);
      handoff(vecs[i].name, vecs[i].res);
    end

    // Hold in DONE with start still high: no relaunch, result stable.
    launch(1'b0, 32'd100, 32'd7);
    wait_done(stalls, ok);
    chk("hold finished", {63'd0, ok}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold stall", {63'd0, div_stall}, 64'd0);
      chk("hold done",  {63'd0, div_done},  64'd1);
      chk("hold res",   div_res, {32'd2, 32'd14});
    end
    @(posedge clk); #1;
    div_accept = 1'b1;
    @(negedge clk);
    chk("accept cycle done", {63'd0, div_done}, 64'd1);
    // Next instruction's divide presents start right after the handoff edge.
    @(posedge clk); #1;
    div_accept = 1'b0;
    div_sign   = 1'b1;
    dividend   = 32'hFFFF_FFF9;
    divisor    = 32'd2;
    wait_done(stalls, ok);
    chk("b2b finished", {63'd0, ok}, 64'd1);
    chk("b2b stall cycles", 64'(stalls), 64'(full_stall));
    chk("b2b res", div_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    handoff("b2b", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    held = {32'hFFFF_FFFF, 32'hFFFF_FFFD};

    // Cancel at T+10.
    launch(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel stall drop", {63'd0, div_stall}, 64'd0);
    @(posedge clk); #1;
    div_cancel = 1'b0;
    div_start  = 1'b0;
    @(negedge clk);
    chk("cancel idle stall", {63'd0, div_stall}, 64'd0);
    chk("cancel done",       {63'd0, div_done},  64'd0);
    chk("cancel res kept",   div_res, held);

    // Cancel together with start in IDLE: no launch.
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel+start stall", {63'd0, div_stall}, 64'd0);
    @(posedge clk); #1;
    div_start  = 1'b0;
    div_cancel = 1'b0;
    @(negedge clk);
    chk("cancel+start no launch", {63'd0, div_stall}, 64'd0);

    // Fresh divide after cancel.
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(stalls, ok);
    chk("post-cancel stall cycles", 64'(stalls), 64'(full_stall));
    chk("post-cancel res", div_res, {32'd1, 32'hFFFF_FFFD});
    handoff("post-cancel", {32'd1, 32'hFFFF_FFFD});

    // Asynchronous reset at T+5.
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("async rst stall", {63'd0, div_stall}, 64'd0);
    chk("async rst done",  {63'd0, div_done},  64'd0);
    chk("async rst res",   div_res, 64'd0);
    div_start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    launch(1'b0, 32'd100, 32'd7);
    wait_done(stalls, ok);
    chk("post-rst stall cycles", 64'(stalls), 64'(full_stall));
    chk("post-rst res", div_res, {32'd2, 32'd14});
    handoff("post-rst", {32'd2, 32'd14});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
